// File: rtl/ahbl_slave_mem.sv
// AHB-Lite responder memory: word-organised storage with byte lanes,
// a fixed number of wait states per accepted transfer and an address
// window that answers with a two-cycle ERROR response.
module ahbl_slave_mem #(
   parameter int          AWIDTH      = 10,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ERR_ADDR_LO = 32'hFFFF_FFFF,
   parameter logic [31:0] ERR_ADDR_HI = 32'h0000_0000,
   parameter int          TPD         = 1
) (
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic        HMASTLOCK,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADYIN,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int         DEPTH     = 2 ** AWIDTH;
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              dp_q, dp_d;         // an OKAY data phase is in progress
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        lane_q, lane_d;
   logic [AWIDTH-1:0] idx_q, idx_d;
   logic              hreadyout_q, hreadyout_d;
   logic              hresp_q, hresp_d;

   logic              accept;
   logic              in_window;
   logic              misalign;
   logic              addr_err;
   logic              mem_we;
   logic [3:0]        byte_en;
   logic [31:0]       rd_word;

   // Bus handshake inputs with no effect on the response. TPD only models
   // an output delay in a timed simulation; the RTL itself is zero-delay.
   logic unused_ok;
   assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, (TPD != 0)};

   assign accept    = HSEL & HTRANS[1] & HREADYIN;
   // LO > HI makes this range empty, which disables the window.
   assign in_window = (HADDR >= ERR_ADDR_LO) && (HADDR <= ERR_ADDR_HI);
   assign misalign  = ((HSIZE == 3'b001) && HADDR[0]) ||
                      ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
   assign addr_err  = in_window | (HSIZE > 3'd2) | misalign;

   // Write commits on the edge that ends an OKAY write data phase.
   assign mem_we = dp_q & hreadyout_q & wr_q;

   // Next-state and next-output computation for the response FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dp_d        = dp_q;
      wr_d        = wr_q;
      size_d      = size_q;
      lane_d      = lane_q;
      idx_d       = idx_q;
      hreadyout_d = hreadyout_q;
      hresp_d     = hresp_q;
      case (state_q)
         // ERR2 is the final (ready) error cycle, so it behaves like IDLE for
         // whatever address phase is on the bus at the same time.
         ST_IDLE, ST_ERR2: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
            dp_d        = 1'b0;
            if (accept) begin
               wr_d   = HWRITE;
               size_d = HSIZE[1:0];
               lane_d = HADDR[1:0];
               idx_d  = HADDR[AWIDTH+1:2];
               if (addr_err) begin
                  state_d     = ST_ERR1;
                  hreadyout_d = 1'b0;
                  hresp_d     = 1'b1;
               end else if (WAIT_STATES > 0) begin
                  state_d     = ST_WAIT;
                  hreadyout_d = 1'b0;
                  cnt_d       = WAIT_INIT;
                  dp_d        = 1'b1;
               end else begin
                  dp_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d     = ST_IDLE;
               hreadyout_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
            dp_d        = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any data phase in flight.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         dp_q        <= 1'b0;
         wr_q        <= 1'b0;
         size_q      <= 2'b00;
         lane_q      <= 2'b00;
         idx_q       <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dp_q        <= dp_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         lane_q      <= lane_d;
         idx_q       <= idx_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // Little-endian lane enables from the captured size and low address bits.
   always_comb begin
      byte_en = 4'b1111;
      case (size_q)
         2'b00:   byte_en = 4'b0001 << lane_q;
         2'b01:   byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // One byte-wide array per lane so each lane writes independently.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         // Lane write, not touched by reset so contents survive it.
         always_ff @(posedge HCLK) begin
            if (mem_we && byte_en[gi]) begin
               lane_mem[idx_q] <= HWDATA[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8] = lane_mem[idx_q];
      end
   endgenerate

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   // Asynchronous read so a write immediately followed by a read of the same
   // word returns the freshly written data.
   assign HRDATA    = (dp_q && !wr_q) ? rd_word : 32'h0000_0000;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Directed bench for ahbl_slave_mem: one instance with no wait states and
// one with three, both with an ERROR window at 0x100..0x1FF.
module tb_ahbl_slave_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel0, hsel3;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic        hmastlock;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready_kill;
   logic        hreadyin;
   logic        ro0, ro3, resp0, resp3;
   logic [31:0] rdata0, rdata3;
   logic        bus_hready, bus_hresp;
   logic [31:0] bus_hrdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign bus_hready = ro0 & ro3;
   assign bus_hresp  = resp0 | resp3;
   assign bus_hrdata = rdata0 | rdata3;
   assign hreadyin   = bus_hready & ~hready_kill;

   ahbl_slave_mem #(
      .AWIDTH(10), .WAIT_STATES(0),
      .ERR_ADDR_LO(32'h0000_0100), .ERR_ADDR_HI(32'h0000_01FF), .TPD(1)
   ) u_dut0 (
      .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock),
      .HPROT(hprot), .HWDATA(hwdata), .HREADYIN(hreadyin),
      .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rdata0)
   );

   ahbl_slave_mem #(
      .AWIDTH(10), .WAIT_STATES(3),
      .ERR_ADDR_LO(32'h0000_0100), .ERR_ADDR_HI(32'h0000_01FF), .TPD(1)
   ) u_dut3 (
      .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock),
      .HPROT(hprot), .HWDATA(hwdata), .HREADYIN(hreadyin),
      .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rdata3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   task automatic addr_phase(input bit use3, input logic [31:0] addr, input bit wr,
                             input logic [2:0] size);
      hsel0  = !use3;
      hsel3  = use3;
      haddr  = addr;
      htrans = 2'b10;
      hwrite = wr;
      hsize  = size;
   endtask

   // Single non-pipelined transfer; reports wait (HREADY low) and ERROR cycles.
   task automatic xfer(input bit use3, input logic [31:0] addr, input bit wr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int low_cyc, output int resp_cyc);
      int  n;
      bit  done;
      addr_phase(use3, addr, wr, size);
      tick();
      bus_idle();
      hwdata   = wr ? wdata : 32'h0;
      low_cyc  = 0;
      resp_cyc = 0;
      rdata    = 32'h0;
      n        = 0;
      done     = 1'b0;
      while (!done && n < 40) begin
         if (bus_hresp) resp_cyc++;
         if (bus_hready) begin
            rdata = bus_hrdata;
            done  = 1'b1;
         end else begin
            low_cyc++;
         end
         tick();
         n++;
      end
      hwdata = 32'h0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL xfer_timeout: addr=%h still not ready after %0d cycles, need ready", addr, n);
      end
      $display("xfer dut%0d %s addr=%h size=%0d wdata=%h rdata=%h low=%0d resp=%0d",
               use3 ? 3 : 0, wr ? "WR" : "RD", addr, size, wdata, rdata, low_cyc, resp_cyc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_idle();
      haddr = 32'h0; hsize = 3'b010; hwdata = 32'h0;
      hburst = 3'b000; hmastlock = 1'b0; hprot = 4'b0011; hready_kill = 1'b0;
      repeat (3) tick();
      checks++; if (ro0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b need 1", ro0); end
      checks++; if (ro3 !== 1'b1) begin errors++; $display("FAIL reset_ready3: got %b need 1", ro3); end
      checks++; if (bus_hresp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b need 0", bus_hresp); end
      checks++; if (bus_hrdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h need 0", bus_hrdata); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      addr_phase(1'b0, 32'h10, 1'b1, 3'b010);
      tick();
      hwdata = 32'hDEAD_BEEF;
      addr_phase(1'b0, 32'h10, 1'b0, 3'b010);
      checks++; if (ro0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b need 1", ro0); end
      tick();
      bus_idle();
      hwdata = 32'h0;
      checks++; if (ro0 !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %b need 1", ro0); end
      checks++; if (rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rdata: got %h need deadbeef", rdata0); end
      checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL b2b_resp: got %b need 0", resp0); end
      tick();
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL b2b_idle_rdata: got %h need 0", rdata0); end
   endtask

   task automatic test_lanes();
      logic [31:0] rd;
      int lo, rs;
      xfer(1'b0, 32'h13, 1'b1, 3'b000, 32'h5AFF_FFFF, rd, lo, rs);
      xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h5AAD_BEEF) begin errors++; $display("FAIL lane_byte3: got %h need 5aadbeef", rd); end
      xfer(1'b0, 32'h12, 1'b1, 3'b001, 32'h1234_FFFF, rd, lo, rs);
      xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL lane_half_hi: got %h need 1234beef", rd); end
      xfer(1'b0, 32'h10, 1'b1, 3'b000, 32'hFFFF_FF77, rd, lo, rs);
      xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h1234_BE77) begin errors++; $display("FAIL lane_byte0: got %h need 1234be77", rd); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      int lo, rs;
      xfer(1'b1, 32'h20, 1'b1, 3'b010, 32'hCAFE_F00D, rd, lo, rs);
      checks++; if (lo !== 3) begin errors++; $display("FAIL ws_write_low: got %0d need 3", lo); end
      xfer(1'b1, 32'h20, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (lo !== 3) begin errors++; $display("FAIL ws_read_low: got %0d need 3", lo); end
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_read_data: got %h need cafef00d", rd); end
      checks++; if (rs !== 0) begin errors++; $display("FAIL ws_read_resp: got %0d need 0", rs); end
   endtask

   task automatic test_pipelined_wait();
      int lo, n;
      addr_phase(1'b1, 32'h50, 1'b1, 3'b010);
      tick();
      hwdata = 32'hA5A5_5A5A;
      addr_phase(1'b1, 32'h50, 1'b0, 3'b010);
      lo = 0; n = 0;
      while (!bus_hready && n < 20) begin lo++; tick(); n++; end
      checks++; if (lo !== 3) begin errors++; $display("FAIL pipe_wr_low: got %0d need 3", lo); end
      tick();
      bus_idle();
      hwdata = 32'h0;
      lo = 0; n = 0;
      while (!bus_hready && n < 20) begin lo++; tick(); n++; end
      checks++; if (lo !== 3) begin errors++; $display("FAIL pipe_rd_low: got %0d need 3", lo); end
      checks++; if (rdata3 !== 32'hA5A5_5A5A) begin errors++; $display("FAIL pipe_rd_data: got %h need a5a55a5a", rdata3); end
      tick();
   endtask

   task automatic test_err_window();
      logic [31:0] rd;
      int lo, rs;
      // 0x1104 aliases word index 0x41 (same as 0x104) but lies outside the window.
      xfer(1'b0, 32'h1104, 1'b1, 3'b010, 32'h1111_2222, rd, lo, rs);
      checks++; if (rs !== 0) begin errors++; $display("FAIL err_alias_wr_resp: got %0d need 0", rs); end
      addr_phase(1'b0, 32'h104, 1'b1, 3'b010);
      tick();
      bus_idle();
      hwdata = 32'h9999_9999;
      checks++; if ({ro0, resp0} !== 2'b01) begin errors++; $display("FAIL err_cycle1: got rdy/resp=%b need 01", {ro0, resp0}); end
      tick();
      checks++; if ({ro0, resp0} !== 2'b11) begin errors++; $display("FAIL err_cycle2: got rdy/resp=%b need 11", {ro0, resp0}); end
      tick();
      hwdata = 32'h0;
      checks++; if ({ro0, resp0} !== 2'b10) begin errors++; $display("FAIL err_after: got rdy/resp=%b need 10", {ro0, resp0}); end
      xfer(1'b0, 32'h104, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2 || rd !== 32'h0) begin errors++; $display("FAIL err_read: got resp=%0d data=%h need 2/0", rs, rd); end
      xfer(1'b0, 32'h1104, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL err_old_value: got %h need 11112222", rd); end
      xfer(1'b0, 32'h100, 1'b0, 3'b000, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2) begin errors++; $display("FAIL err_lo_edge: got resp=%0d need 2", rs); end
      xfer(1'b0, 32'h1FF, 1'b0, 3'b000, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2) begin errors++; $display("FAIL err_hi_edge: got resp=%0d need 2", rs); end
      xfer(1'b0, 32'h0FF, 1'b0, 3'b000, 32'h0, rd, lo, rs);
      checks++; if (rs !== 0) begin errors++; $display("FAIL err_below: got resp=%0d need 0", rs); end
      xfer(1'b0, 32'h200, 1'b0, 3'b000, 32'h0, rd, lo, rs);
      checks++; if (rs !== 0) begin errors++; $display("FAIL err_above: got resp=%0d need 0", rs); end
      // Wait-state slave must still give a 2-cycle error with one low cycle.
      xfer(1'b1, 32'h104, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2 || lo !== 1) begin errors++; $display("FAIL err_ws: got resp=%0d low=%0d need 2/1", rs, lo); end
   endtask

   task automatic test_illegal_and_ignored();
      logic [31:0] rd;
      int lo, rs;
      xfer(1'b0, 32'h12, 1'b1, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2) begin errors++; $display("FAIL misalign_word: got resp=%0d need 2", rs); end
      xfer(1'b0, 32'h11, 1'b1, 3'b001, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2) begin errors++; $display("FAIL misalign_half: got resp=%0d need 2", rs); end
      xfer(1'b0, 32'h10, 1'b1, 3'b011, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2) begin errors++; $display("FAIL bad_size: got resp=%0d need 2", rs); end
      xfer(1'b0, 32'h02, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rs !== 2) begin errors++; $display("FAIL misalign_rd02: got resp=%0d need 2", rs); end
      xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h1234_BE77) begin errors++; $display("FAIL err_no_write: got %h need 1234be77", rd); end
      xfer(1'b0, 32'h30, 1'b1, 3'b010, 32'h0F0F_0F0F, rd, lo, rs);
      addr_phase(1'b0, 32'h30, 1'b1, 3'b010);
      htrans = 2'b00;
      tick();
      hwdata = 32'hBAD0_BAD0;
      htrans = 2'b01;
      checks++; if ({ro0, resp0} !== 2'b10) begin errors++; $display("FAIL idle_beat: got rdy/resp=%b need 10", {ro0, resp0}); end
      tick();
      htrans = 2'b10;
      hready_kill = 1'b1;
      checks++; if ({ro0, resp0} !== 2'b10) begin errors++; $display("FAIL busy_beat: got rdy/resp=%b need 10", {ro0, resp0}); end
      tick();
      hready_kill = 1'b0;
      bus_idle();
      checks++; if ({ro0, resp0} !== 2'b10) begin errors++; $display("FAIL notready_beat: got rdy/resp=%b need 10", {ro0, resp0}); end
      tick();
      hwdata = 32'h0;
      xfer(1'b0, 32'h30, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h0F0F_0F0F) begin errors++; $display("FAIL ignored_no_write: got %h need 0f0f0f0f", rd); end
   endtask

   task automatic test_reset_mid_phase();
      logic [31:0] rd;
      int lo, rs;
      xfer(1'b1, 32'h40, 1'b1, 3'b010, 32'h0102_0304, rd, lo, rs);
      addr_phase(1'b1, 32'h40, 1'b1, 3'b010);
      tick();
      bus_idle();
      hwdata = 32'hFFFF_FFFF;
      tick();
      checks++; if (ro3 !== 1'b0) begin errors++; $display("FAIL rst_wr_inwait: got %b need 0", ro3); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({ro3, resp3} !== 2'b10) begin errors++; $display("FAIL rst_wr_outputs: got rdy/resp=%b need 10", {ro3, resp3}); end
      tick();
      rst_n = 1'b1;
      hwdata = 32'h0;
      repeat (2) tick();
      xfer(1'b1, 32'h40, 1'b0, 3'b010, 32'h0, rd, lo, rs);
      checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL rst_word_kept: got %h need 01020304", rd); end
      addr_phase(1'b1, 32'h40, 1'b0, 3'b010);
      tick();
      bus_idle();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rst_rd_rdata: got %h need 0", rdata3); end
      checks++; if (ro3 !== 1'b1) begin errors++; $display("FAIL rst_rd_ready: got %b need 1", ro3); end
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      #1;
      test_reset();
      test_back_to_back();
      test_lanes();
      test_wait_states();
      test_pipelined_wait();
      test_err_window();
      test_illegal_and_ignored();
      test_reset_mid_phase();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
